// File: rtl/fix_to_float16.sv
// Signed two's-complement fixed-point to float16 converter, four register stages.
// Float16 here has no subnormals: a zero exponent field means zero, overflow saturates.
module fix_to_float16 #(
  parameter int IN_W      = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            de_in,
  input  logic [IN_W-1:0] data_in,
  output logic            de_out,
  output logic [15:0]     data_out
);

  localparam int PW = $clog2(IN_W);
  localparam int XW = IN_W + 11;
  localparam logic signed [7:0] E_BASE = 8'(15 - FRAC_BITS);

  // Stage 1: sign and magnitude
  logic            s1_de, s1_sign;
  logic [IN_W-1:0] s1_mag;
  // Stage 2: leading-one position
  logic            s2_de, s2_sign, s2_zero;
  logic [IN_W-1:0] s2_mag;
  logic [PW-1:0]   s2_p;
  // Stage 3: normalized mantissa with guard/sticky
  logic            s3_de, s3_sign, s3_zero, s3_g, s3_s;
  logic [9:0]      s3_keep;
  logic signed [7:0] s3_e;

  logic [IN_W-1:0] mag_c;
  logic [PW-1:0]   p_c;
  logic [IN_W-1:0] shifted_c;
  logic [XW-1:0]   ext_c;
  logic            inc_c;
  logic [10:0]     sum_c;
  logic signed [7:0] e_rnd_c;
  logic [15:0]     res_c;

  // The most negative input negates onto itself, which read as unsigned is the right magnitude.
  always_comb begin
    mag_c = data_in[IN_W-1] ? (~data_in + IN_W'(1)) : data_in;
  end

  always_comb begin
    p_c = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag[i]) p_c = PW'(i);
    end
  end

  // Hidden one lands at the top of ext_c; the bits below it split into keep, G and sticky.
  always_comb begin
    shifted_c = s2_mag << (PW'(IN_W - 1) - s2_p);
    ext_c     = {shifted_c, 11'b0};
  end

  always_comb begin
    inc_c   = s3_g & (s3_s | s3_keep[0]);
    sum_c   = {1'b0, s3_keep} + {10'b0, inc_c};
    e_rnd_c = sum_c[10] ? (s3_e + 8'sd1) : s3_e;
    if (s3_zero)
      res_c = 16'h0000;
    else if (e_rnd_c <= 8'sd0)
      res_c = 16'h0000;
    else if (e_rnd_c >= 8'sd31)
      res_c = {s3_sign, 5'd31, 10'h3FF};
    else
      res_c = {s3_sign, e_rnd_c[4:0], sum_c[9:0]};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_de    <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s2_de    <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_mag   <= '0;
      s2_p     <= '0;
      s3_de    <= 1'b0;
      s3_sign  <= 1'b0;
      s3_zero  <= 1'b0;
      s3_g     <= 1'b0;
      s3_s     <= 1'b0;
      s3_keep  <= '0;
      s3_e     <= '0;
      de_out   <= 1'b0;
      data_out <= 16'h0000;
    end else begin
      s1_de    <= de_in;
      s1_sign  <= data_in[IN_W-1];
      s1_mag   <= mag_c;
      s2_de    <= s1_de;
      s2_sign  <= s1_sign;
      s2_zero  <= (s1_mag == '0);
      s2_mag   <= s1_mag;
      s2_p     <= p_c;
      s3_de    <= s2_de;
      s3_sign  <= s2_sign;
      s3_zero  <= s2_zero | ~shifted_c[IN_W-1];
      s3_keep  <= ext_c[XW-2 -: 10];
      s3_g     <= ext_c[XW-12];
      s3_s     <= |ext_c[XW-13:0];
      s3_e     <= E_BASE + 8'(s2_p);
      de_out   <= s3_de;
      data_out <= res_c;
    end
  end

endmodule

// File: tb/tb_fix_to_float16.sv
// Bench for fix_to_float16: three parameterizations driven side by side, table vectors
// plus random traffic scored against an integer-arithmetic float16 model.
module tb_fix_to_float16;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        de_in;
  logic [15:0] din_a, din_c;
  logic [31:0] din_b;
  logic        de_a, de_b, de_c;
  logic [15:0] dout_a, dout_b, dout_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] exp_c[$];
  logic [3:0]  de_hist;

  typedef struct {
    int          sel;
    logic [31:0] din;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;

  fix_to_float16 #(.IN_W(16), .FRAC_BITS(0)) dut_a (
    .clk(clk), .rst_b(rst_b), .de_in(de_in), .data_in(din_a), .de_out(de_a), .data_out(dout_a));
  fix_to_float16 #(.IN_W(32), .FRAC_BITS(0)) dut_b (
    .clk(clk), .rst_b(rst_b), .de_in(de_in), .data_in(din_b), .de_out(de_b), .data_out(dout_b));
  fix_to_float16 #(.IN_W(16), .FRAC_BITS(15)) dut_c (
    .clk(clk), .rst_b(rst_b), .de_in(de_in), .data_in(din_c), .de_out(de_c), .data_out(dout_c));

  // Reference: value = v / 2^f, rounded to 11 significant bits, nearest-even.
  function automatic logic [15:0] model(input longint v, input int f);
    logic   s;
    longint mag, q, rem, half;
    int     p, e, sh;
    s   = (v < 0);
    mag = s ? -v : v;
    if (mag == 0) return 16'h0000;
    p = 0;
    while ((longint'(1) << (p + 1)) <= mag) p++;
    if (p <= 10) begin
      q = mag << (10 - p);
    end else begin
      sh   = p - 10;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 2048) begin
        q = 1024;
        p++;
      end
    end
    e = 15 + p - f;
    if (e <= 0) return 16'h0000;
    if (e >= 31) return {s, 5'd31, 10'h3FF};
    return {s, 5'(e), 10'(q - 1024)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; sel picks which DUT takes tab_exp instead of the model.
  task automatic send(input logic de, input logic [15:0] a, input logic [31:0] b,
                      input logic [15:0] c, input int sel, input logic [15:0] tab_exp);
    de_in = de;
    din_a = a;
    din_b = b;
    din_c = c;
    if (de) begin
      exp_a.push_back(sel == 0 ? tab_exp : model(longint'($signed(a)), 0));
      exp_b.push_back(sel == 1 ? tab_exp : model(longint'($signed(b)), 0));
      exp_c.push_back(sel == 2 ? tab_exp : model(longint'($signed(c)), 15));
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) w = -w;
    return w;
  endfunction

  task automatic send_rand(input logic de);
    logic [31:0] w1, w2, w3;
    w1 = rand_word();
    w2 = rand_word();
    w3 = rand_word();
    send(de, w1[15:0], w2, w3[15:0], -1, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 16'h0, 32'h0, 16'h0, -1, 16'h0);
  endtask

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) de_hist <= 4'b0;
    else        de_hist <= {de_hist[2:0], de_in};
  end

  // Scoreboard: valid must be de_in four clocks late; each valid result pops its expectation.
  always @(negedge clk) begin
    if (rst_b) begin
      chk("de_a_timing", {15'b0, de_a}, {15'b0, de_hist[3]});
      chk("de_b_timing", {15'b0, de_b}, {15'b0, de_hist[3]});
      chk("de_c_timing", {15'b0, de_c}, {15'b0, de_hist[3]});
      if (de_a) begin
        if (exp_a.size() == 0) chk("a_unexpected", dout_a, 16'hxxxx);
        else chk("a_data", dout_a, exp_a.pop_front());
      end
      if (de_b) begin
        if (exp_b.size() == 0) chk("b_unexpected", dout_b, 16'hxxxx);
        else chk("b_data", dout_b, exp_b.pop_front());
      end
      if (de_c) begin
        if (exp_c.size() == 0) chk("c_unexpected", dout_c, 16'hxxxx);
        else chk("c_data", dout_c, exp_c.pop_front());
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_de_a"}, {15'b0, de_a}, 16'h0);
    chk({tag, "_de_b"}, {15'b0, de_b}, 16'h0);
    chk({tag, "_de_c"}, {15'b0, de_c}, 16'h0);
    chk({tag, "_do_a"}, dout_a, 16'h0);
    chk({tag, "_do_b"}, dout_b, 16'h0);
    chk({tag, "_do_c"}, dout_c, 16'h0);
  endtask

  initial begin
    vecs[0]  = '{0, 32'h0000_0001, 16'h3C00};
    vecs[1]  = '{0, 32'h0000_FFFE, 16'hC000};
    vecs[2]  = '{0, 32'h0000_0000, 16'h0000};
    vecs[3]  = '{0, 32'h0000_7FFF, 16'h7800};
    vecs[4]  = '{0, 32'h0000_8000, 16'hF800};
    vecs[5]  = '{0, 32'd2049,      16'h6800};
    vecs[6]  = '{0, 32'd2051,      16'h6802};
    vecs[7]  = '{1, 32'd65504,     16'h7BFF};
    vecs[8]  = '{1, 32'd65520,     16'h7FFF};
    vecs[9]  = '{1, 32'hFFFF_0000, 16'hFFFF};
    vecs[10] = '{2, 32'h0000_0001, 16'h0000};
    vecs[11] = '{2, 32'h0000_0002, 16'h0400};
    vecs[12] = '{2, 32'h0000_4000, 16'h3800};
    vecs[13] = '{2, 32'h0000_C000, 16'hB800};

    rst_b = 1'b0;
    de_in = 1'b0;
    din_a = '0;
    din_b = '0;
    din_c = '0;
    #12;
    chk_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle(3);

    for (int i = 0; i < 14; i++) begin
      logic [31:0] w1, w2;
      w1 = rand_word();
      w2 = rand_word();
      case (vecs[i].sel)
        0:       send(1'b1, vecs[i].din[15:0], w1, w2[15:0], 0, vecs[i].exp);
        1:       send(1'b1, w1[15:0], vecs[i].din, w2[15:0], 1, vecs[i].exp);
        default: send(1'b1, w1[15:0], w2, vecs[i].din[15:0], 2, vecs[i].exp);
      endcase
      idle(1);
    end
    idle(5);

    for (int i = 0; i < 20; i++) send_rand(1'b1);
    idle(3);
    for (int i = 0; i < 5; i++) send_rand(1'b1);
    idle(5);

    for (int i = 0; i < 200; i++) send_rand($urandom_range(0, 2) != 0);
    idle(5);

    // Reset while three values are still inside the pipeline.
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    rst_b = 1'b0;
    de_in = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    exp_a.delete();
    exp_b.delete();
    exp_c.delete();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle(6);
    send(1'b1, 16'h0001, 32'd65504, 16'h4000, -1, 16'h0);
    idle(6);

    chk("a_drain", 16'(exp_a.size()), 16'h0);
    chk("b_drain", 16'(exp_b.size()), 16'h0);
    chk("c_drain", 16'(exp_c.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
